// File: rtl/pcw_sdram_loader_port.sv
// Boot-loader SDRAM port: buffers starter byte writes in a small FIFO and
// shares the SDRAM byte port with the CPU (loader first, CPU stalled while loading).
`timescale 1ns/1ps
module pcw_sdram_loader_port #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BOOT_BASE  = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              starter_wr,
    input  logic [15:0]       starter_addr,
    input  logic [7:0]        starter_data,
    input  logic              starter_active,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [7:0]        sdram_din,
    input  logic [7:0]        sdram_dout,
    input  logic              sdram_ack,
    output logic              loader_busy,
    output logic              fifo_overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        STARTER,
        CPU,
        CPU_DONE
    } state_t;

    state_t             state, state_n;
    logic               starter_wr_q;
    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [7:0]         fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_n;
    logic               push_edge, fifo_full, fifo_push, fifo_pop;
    logic [ADDR_W-1:0]  push_addr;

    logic               req_n, we_n, wait_n, busy_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [7:0]         din_n, dout_n;

    assign push_edge = starter_wr & ~starter_wr_q;
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_pop  = (state == STARTER) & sdram_ack;
    // A push into a full FIFO survives only if the head retires on the same edge.
    assign fifo_push = push_edge & (~fifo_full | fifo_pop);
    assign push_addr = BOOT_BASE + ADDR_W'(starter_addr);

    always_comb begin
        count_n = count;
        if (fifo_push && !fifo_pop) begin
            count_n = count + 1'b1;
        end else if (!fifo_push && fifo_pop) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (fifo_push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= starter_data;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = sdram_req;
        we_n    = sdram_we;
        addr_n  = sdram_addr;
        din_n   = sdram_din;
        dout_n  = cpu_dout;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    addr_n  = fifo_addr[rd_ptr];
                    din_n   = fifo_data[rd_ptr];
                    we_n    = 1'b1;
                    req_n   = 1'b1;
                    state_n = STARTER;
                end else if (!starter_active && (cpu_rd || cpu_wr)) begin
                    addr_n  = cpu_addr;
                    din_n   = cpu_din;
                    we_n    = cpu_wr;
                    req_n   = 1'b1;
                    state_n = CPU;
                end
            end
            STARTER: begin
                if (sdram_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            CPU: begin
                if (sdram_ack) begin
                    req_n = 1'b0;
                    if (!sdram_we) begin
                        dout_n = sdram_dout;
                    end
                    state_n = CPU_DONE;
                end
            end
            CPU_DONE: begin
                if (!cpu_rd && !cpu_wr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Status flags look at next-cycle state so wait falls together with cpu_dout.
        wait_n = (cpu_rd | cpu_wr) & (state_n != CPU_DONE);
        busy_n = (count_n != '0) | (state_n == STARTER);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state         <= IDLE;
            starter_wr_q  <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
            sdram_req     <= 1'b0;
            sdram_we      <= 1'b0;
            sdram_addr    <= '0;
            sdram_din     <= '0;
            cpu_dout      <= '0;
            cpu_wait      <= 1'b0;
            loader_busy   <= 1'b0;
        end else begin
            state        <= state_n;
            starter_wr_q <= starter_wr;
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
            if (push_edge && fifo_full && !fifo_pop) begin
                fifo_overflow <= 1'b1;
            end
            sdram_req   <= req_n;
            sdram_we    <= we_n;
            sdram_addr  <= addr_n;
            sdram_din   <= din_n;
            cpu_dout    <= dout_n;
            cpu_wait    <= wait_n;
            loader_busy <= busy_n;
        end
    end

endmodule

// File: tb/tb_pcw_sdram_loader_port.sv
// Directed bench for pcw_sdram_loader_port: two instances (base 0 and base
// 0x7F0000) share stimulus; expectations are hand-derived cycle by cycle.
`timescale 1ns/1ps
module tb_pcw_sdram_loader_port;

    logic        clk_sys;
    logic        reset_n;
    logic        starter_wr;
    logic [15:0] starter_addr;
    logic [7:0]  starter_data;
    logic        starter_active;
    logic        cpu_rd, cpu_wr;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  sdram_dout;
    logic        sdram_ack;

    logic [7:0]  cpu_dout, hi_cpu_dout;
    logic        cpu_wait, hi_cpu_wait;
    logic        sdram_req, hi_sdram_req;
    logic        sdram_we, hi_sdram_we;
    logic [22:0] sdram_addr, hi_sdram_addr;
    logic [7:0]  sdram_din, hi_sdram_din;
    logic        loader_busy, hi_loader_busy;
    logic        fifo_overflow, hi_fifo_overflow;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    pcw_sdram_loader_port #(.ADDR_W(23), .BOOT_BASE(23'h000000), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .starter_wr(starter_wr), .starter_addr(starter_addr), .starter_data(starter_data),
        .starter_active(starter_active),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_dout(sdram_dout), .sdram_ack(sdram_ack),
        .loader_busy(loader_busy), .fifo_overflow(fifo_overflow)
    );

    pcw_sdram_loader_port #(.ADDR_W(23), .BOOT_BASE(23'h7F0000), .FIFO_DEPTH(4)) dut_hi (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .starter_wr(starter_wr), .starter_addr(starter_addr), .starter_data(starter_data),
        .starter_active(starter_active),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(hi_cpu_dout), .cpu_wait(hi_cpu_wait),
        .sdram_req(hi_sdram_req), .sdram_we(hi_sdram_we), .sdram_addr(hi_sdram_addr),
        .sdram_din(hi_sdram_din), .sdram_dout(sdram_dout), .sdram_ack(sdram_ack),
        .loader_busy(hi_loader_busy), .fifo_overflow(hi_fifo_overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising starter_wr edge, then low for a cycle so the next one registers.
    task automatic swrite(input logic [15:0] a, input logic [7:0] d);
        starter_addr = a;
        starter_data = d;
        starter_wr   = 1'b1;
        tick();
        starter_wr   = 1'b0;
        tick();
    endtask

    task automatic wait_req(input string tag);
        int unsigned n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sdram_req}, 32'd1);
    endtask

    task automatic ack_once();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        starter_wr     = 1'b0;
        starter_addr   = '0;
        starter_data   = '0;
        starter_active = 1'b0;
        cpu_rd         = 1'b0;
        cpu_wr         = 1'b0;
        cpu_addr       = '0;
        cpu_din        = '0;
        sdram_dout     = '0;
        sdram_ack      = 1'b0;
        tick(); tick(); tick();

        // Reset values
        chk("rst_req",   {31'd0, sdram_req},     32'd0);
        chk("rst_we",    {31'd0, sdram_we},      32'd0);
        chk("rst_addr",  {9'd0, sdram_addr},     32'd0);
        chk("rst_din",   {24'd0, sdram_din},     32'd0);
        chk("rst_dout",  {24'd0, cpu_dout},      32'd0);
        chk("rst_wait",  {31'd0, cpu_wait},      32'd0);
        chk("rst_busy",  {31'd0, loader_busy},   32'd0);
        chk("rst_ovf",   {31'd0, fifo_overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Two starter writes, ack two cycles after each request
        starter_addr = 16'h0000; starter_data = 8'h3E; starter_wr = 1'b1;
        tick();
        chk("s1_busy_after_push", {31'd0, loader_busy}, 32'd1);
        chk("s1_no_req_yet",      {31'd0, sdram_req},   32'd0);
        starter_wr = 1'b0;
        tick();
        chk("s1_req0",  {31'd0, sdram_req},  32'd1);
        chk("s1_addr0", {9'd0, sdram_addr},  32'h000000);
        chk("s1_din0",  {24'd0, sdram_din},  32'h3E);
        chk("s1_we0",   {31'd0, sdram_we},   32'd1);
        starter_addr = 16'h0001; starter_data = 8'hC3; starter_wr = 1'b1;
        tick();
        starter_wr = 1'b0;
        chk("s1_hold_addr0", {9'd0, sdram_addr}, 32'h000000);
        ack_once();
        chk("s1_req_gap",    {31'd0, sdram_req},   32'd0);
        chk("s1_busy_mid",   {31'd0, loader_busy}, 32'd1);
        tick();
        chk("s1_req1",  {31'd0, sdram_req},  32'd1);
        chk("s1_addr1", {9'd0, sdram_addr},  32'h000001);
        chk("s1_din1",  {24'd0, sdram_din},  32'hC3);
        chk("s1_we1",   {31'd0, sdram_we},   32'd1);
        chk("s1_hi_addr1", {9'd0, hi_sdram_addr}, 32'h7F0001);
        tick();
        chk("s1_busy_before_ack", {31'd0, loader_busy}, 32'd1);
        ack_once();
        chk("s1_req_done",  {31'd0, sdram_req},   32'd0);
        chk("s1_busy_fall", {31'd0, loader_busy}, 32'd0);
        tick();

        // BOOT_BASE offset and wrap
        swrite(16'hFFFF, 8'h11);
        chk("s2_lo_ffff", {9'd0, sdram_addr},    32'h00FFFF);
        chk("s2_hi_ffff", {9'd0, hi_sdram_addr}, 32'h7FFFFF);
        ack_once();
        swrite(16'h0010, 8'h22);
        chk("s2_lo_0010", {9'd0, sdram_addr},    32'h000010);
        chk("s2_hi_0010", {9'd0, hi_sdram_addr}, 32'h7F0010);
        chk("s2_din",     {24'd0, hi_sdram_din}, 32'h22);
        ack_once();
        tick();

        // Overflow: six pushes with acks withheld
        for (int i = 0; i < 6; i++) begin
            starter_addr = 16'h0100 + 16'(i);
            starter_data = 8'h50 + 8'(i);
            starter_wr   = 1'b1;
            tick();
            if (i == 3) chk("s3_ovf_at_full", {31'd0, fifo_overflow}, 32'd0);
            starter_wr = 1'b0;
            tick();
        end
        chk("s3_ovf_set", {31'd0, fifo_overflow}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_req("s3_req_timeout");
            chk("s3_drain_addr", {9'd0, sdram_addr}, 32'h000100 + k);
            chk("s3_drain_din",  {24'd0, sdram_din}, 32'h50 + k);
            ack_once();
        end
        tick(); tick(); tick();
        chk("s3_no_fifth", {31'd0, sdram_req},     32'd0);
        chk("s3_idle",     {31'd0, loader_busy},   32'd0);
        chk("s3_sticky",   {31'd0, fifo_overflow}, 32'd1);

        // CPU read held off while the starter is active
        starter_active = 1'b1;
        cpu_addr       = 23'h001234;
        cpu_rd         = 1'b1;
        tick();
        chk("s4_wait_on", {31'd0, cpu_wait}, 32'd1);
        tick(); tick();
        chk("s4_no_req",   {31'd0, sdram_req}, 32'd0);
        chk("s4_wait_hold", {31'd0, cpu_wait}, 32'd1);
        starter_active = 1'b0;
        tick();
        chk("s4_req",  {31'd0, sdram_req}, 32'd1);
        chk("s4_we",   {31'd0, sdram_we},  32'd0);
        chk("s4_addr", {9'd0, sdram_addr}, 32'h001234);
        chk("s4_wait_busy", {31'd0, cpu_wait}, 32'd1);
        sdram_dout = 8'hA5;
        ack_once();
        sdram_dout = 8'h00;
        chk("s4_dout",     {24'd0, cpu_dout}, 32'hA5);
        chk("s4_wait_off", {31'd0, cpu_wait}, 32'd0);
        chk("s4_req_off",  {31'd0, sdram_req}, 32'd0);
        tick(); tick(); tick();
        chk("s4_single_access", {31'd0, sdram_req}, 32'd0);
        chk("s4_wait_stays_off", {31'd0, cpu_wait}, 32'd0);
        cpu_rd = 1'b0;
        tick();
        chk("s4_dout_held", {24'd0, cpu_dout}, 32'hA5);

        // Starter entry takes priority over a pending CPU write
        starter_addr = 16'h0020; starter_data = 8'h99; starter_wr = 1'b1;
        tick();
        starter_wr = 1'b0;
        cpu_wr     = 1'b1;
        cpu_addr   = 23'h000ABC;
        cpu_din    = 8'h77;
        tick();
        chk("s5_starter_first", {9'd0, sdram_addr}, 32'h000020);
        chk("s5_starter_din",   {24'd0, sdram_din}, 32'h99);
        chk("s5_cpu_waits",     {31'd0, cpu_wait},  32'd1);
        ack_once();
        chk("s5_gap", {31'd0, sdram_req}, 32'd0);
        tick();
        chk("s5_cpu_req",  {31'd0, sdram_req}, 32'd1);
        chk("s5_cpu_addr", {9'd0, sdram_addr}, 32'h000ABC);
        chk("s5_cpu_din",  {24'd0, sdram_din}, 32'h77);
        chk("s5_cpu_we",   {31'd0, sdram_we},  32'd1);
        ack_once();
        chk("s5_wait_off",   {31'd0, cpu_wait},  32'd0);
        chk("s5_dout_kept",  {24'd0, cpu_dout},  32'hA5);
        cpu_wr = 1'b0;
        tick();

        // Reset in the middle of a starter transaction
        for (int i = 0; i < 3; i++) begin
            swrite(16'h0200 + 16'(i), 8'h60 + 8'(i));
        end
        chk("s6_in_flight", {31'd0, sdram_req},   32'd1);
        chk("s6_busy",      {31'd0, loader_busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("s6_req_cleared",  {31'd0, sdram_req},     32'd0);
        chk("s6_busy_cleared", {31'd0, loader_busy},   32'd0);
        chk("s6_ovf_cleared",  {31'd0, fifo_overflow}, 32'd0);
        reset_n = 1'b1;
        ack_once();
        tick(); tick();
        chk("s6_fifo_empty", {31'd0, sdram_req},   32'd0);
        chk("s6_still_idle", {31'd0, loader_busy}, 32'd0);
        chk("s6_addr_reset", {9'd0, sdram_addr},   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcw_sdram_loader_port.md
Name: pcw_sdram_loader_port

Overview:
- Downstream of the boot starter; sits between it and the SDRAM controller's byte port.
- Captures the starter's slot-paced byte writes into a small FIFO and drains them to SDRAM over a req/ack handshake.
- Arbitrates the same SDRAM port for CPU reads and writes, and holds the CPU in wait while boot code is loading.
- Reports loader_busy so exec hand-off can be delayed until every boot byte has landed.

Parameters:
- ADDR_W, 23: SDRAM byte-address width.
- BOOT_BASE, 23'h000000: SDRAM byte address that starter address 0 maps to.
- FIFO_DEPTH, 4: starter write FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- starter_wr  in  1  starter write strobe; level held for one or more cycles, one write per rising edge.
- starter_addr  in  16  starter byte address.
- starter_data  in  8  starter write data.
- starter_active  in  1  starter is loading.
- cpu_rd  in  1  CPU read request (level).
- cpu_wr  in  1  CPU write request (level).
- cpu_addr  in  ADDR_W  CPU SDRAM byte address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- cpu_wait  out  1  CPU wait request.
- sdram_req  out  1  SDRAM request.
- sdram_we  out  1  1 = write, 0 = read.
- sdram_addr  out  ADDR_W  SDRAM byte address.
- sdram_din  out  8  SDRAM write data.
- sdram_dout  in  8  SDRAM read data; valid on the sdram_ack cycle.
- sdram_ack  in  1  one-cycle completion pulse.
- loader_busy  out  1  FIFO non-empty or starter transaction in flight.
- fifo_overflow  out  1  sticky: a starter write was dropped.

Behaviour:
Reset:
- When reset_n = 0 at an edge, all outputs go to 0: sdram_req, sdram_we, sdram_addr, sdram_din, cpu_dout, loader_busy, fifo_overflow.
- cpu_wait also goes to 0.
- FIFO pointers are cleared, the starter_wr edge register is cleared, and state goes to IDLE.
- Reset mid-transaction abandons the request: sdram_req is 0 on the first cycle after reset. A late sdram_ack after reset is ignored.

Capture:
- A push occurs when starter_wr = 1 and the registered previous starter_wr = 0.
- Entry contents: address = BOOT_BASE + zero-extended starter_addr (mod 2^ADDR_W); data = starter_data; both sampled on the push cycle.
- Push when full and no pop that cycle: the entry is dropped and fifo_overflow is set. It stays set until reset.
- Push and pop on the same cycle when full: both take effect, no overflow.
- Count width = log2(FIFO_DEPTH) + 1.

Arbiter FSM (IDLE, STARTER, CPU, CPU_DONE):
- IDLE, FIFO non-empty: load the head entry onto sdram_addr/sdram_din, set sdram_we = 1 and sdram_req = 1, go to STARTER. The FIFO has priority over the CPU.
- IDLE, FIFO empty, starter_active = 0, and (cpu_rd | cpu_wr): drive cpu_addr and cpu_din, set sdram_we = cpu_wr and sdram_req = 1, go to CPU. If both cpu_rd and cpu_wr are high, it is treated as a write.
- STARTER: hold req, addr, din and we stable until sdram_ack. On ack: clear sdram_req, pop the FIFO, go to IDLE.
- CPU: hold stable until ack. On ack: clear sdram_req; on a read, latch sdram_dout into cpu_dout; go to CPU_DONE.
- CPU_DONE: stay until cpu_rd = 0 and cpu_wr = 0, then go to IDLE. This gives exactly one access per strobe.
- sdram_ack outside STARTER or CPU is ignored.

Outputs:
- cpu_wait is registered.
- cpu_wait = 1 whenever (cpu_rd | cpu_wr) is high and the state is not CPU_DONE.
- cpu_wait drops on the cycle after the ack.
- loader_busy = (count != 0) | (state == STARTER), registered.

Latency:
- starter_wr rises at edge N: entry is present after N; sdram_req = 1 after N+1 if the FSM was idle.
- Back-to-back FIFO entries: one cycle of sdram_req = 0 between transactions.

Test Plan:
- Reset, then starter writes addr 0x0000 data 0x3E and addr 0x0001 data 0xC3, ack two cycles after each req -> sdram_addr 0x000000 then 0x000001 with matching din and sdram_we = 1; loader_busy falls one cycle after the second ack.
- BOOT_BASE = 23'h7F0000, starter addr 0xFFFF -> sdram_addr 23'h7FFFFF. Same BOOT_BASE, addr 0x0010 -> 23'h7F0010.
- 6 starter writes with ack withheld -> FIFO holds 4, fifo_overflow = 1 after the 6th push. Releasing acks drains exactly the first 4 (incl. the head already in flight); the flag stays 1.
- CPU read 0x001234 while starter_active = 1 -> cpu_wait stays 1, no CPU req. Drop starter_active, then ack with sdram_dout 0xA5 -> cpu_dout = 0xA5, cpu_wait = 0 next cycle, no second req while cpu_rd remains high.
- CPU write pending while a starter push arrives in IDLE -> the starter transaction is issued first and the CPU write follows after its ack.
- Assert reset_n = 0 mid-STARTER with 3 entries queued -> sdram_req = 0 next cycle, loader_busy = 0, FIFO empty; a stray ack is ignored.
